inst_mgmt: RTL and testbench

- Instruction-management stage between instruction memory and decode in the RISC-V core.
- Takes the raw word fetched from memory (rdata) and, under control of the hazard/branch unit (inst_sel), forwards one of three things to decode:
  - the new instruction,
  - a held copy of the previous instruction (stall), or
  - a NOP bubble (flush).
- Keeps one internal instruction register so that stalls are glitch-free.

---
 rtl/inst_mgmt.sv | 56 +++++
 tb/tb_inst_mgmt.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mgmt.sv
// Instruction-management stage: forwards fetched word, held copy, or NOP bubble to decode.
// Latency: rdata->inst 0 cycles (combinational), rdata->r_inst_q 1 cycle.
// Backpressure: none; stall is expressed by inst_sel=HOLD, which replays the last delivered word.
//
// Ports:
//   clk      - system clock, r_inst_q updates on rising edge
//   rst      - asynchronous active-low reset (0 = reset)
//   rdata    - instruction word from instruction memory this cycle
//   inst_sel - 00 fetch, 01 hold, 10 flush, 11 reserved (flush)
//   inst     - instruction presented to decode
module inst_mgmt #(
  parameter int unsigned      XLEN     = 32,
  parameter logic [XLEN-1:0]  NOP_INST = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      inst_sel,
  output logic [XLEN-1:0] inst
);

  localparam logic [1:0] SEL_FETCH = 2'b00;
  localparam logic [1:0] SEL_HOLD  = 2'b01;
  localparam logic [1:0] SEL_FLUSH = 2'b10;

  // Last word delivered to decode; source for HOLD.
  logic [XLEN-1:0] r_inst_q;
  logic [XLEN-1:0] w_inst_mux;

  // Reserved and unknown selects both fall to the default arm so a bad
  // control encoding becomes a bubble instead of a bogus instruction.
  always_comb begin
    w_inst_mux = NOP_INST;
    case (inst_sel)
      SEL_FETCH: w_inst_mux = rdata;
      SEL_HOLD:  w_inst_mux = r_inst_q;
      SEL_FLUSH: w_inst_mux = NOP_INST;
      default:   w_inst_mux = NOP_INST;
    endcase
  end

  // Reset gates the output directly so decode sees a bubble for the whole
  // reset window, independent of select and memory data.
  assign inst = rst ? w_inst_mux : NOP_INST;

  // Capture what was actually delivered in every mode, so a multi-cycle
  // hold stays constant and a hold after a flush replays the bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_inst_q <= NOP_INST;
    end else begin
      r_inst_q <= w_inst_mux;
    end
  end

endmodule

// File: tb/tb_inst_mgmt.sv
module tb_inst_mgmt;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic [31:0] rdata;
  logic [1:0]  inst_sel;
  logic [31:0] inst;

  int n_cmp = 0;
  int n_err = 0;

  inst_mgmt #(
    .XLEN     (32),
    .NOP_INST (32'h0000_0013)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rdata    (rdata),
    .inst_sel (inst_sel),
    .inst     (inst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 1 time unit later,
  // well away from the rising edge that updates the register.
  task automatic test_reset();
    rst      = 1'b0;
    inst_sel = 2'b00;
    rdata    = 32'h0050_0093;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      n_cmp++;
      if (inst !== NOP) begin
        n_err++;
        $display("FAIL reset_cycle%0d: inst=%08h expected=%08h", c, inst, NOP);
      end
    end
    // Leave reset holding: the register must have been cleared to the bubble.
    @(negedge clk);
    rst      = 1'b1;
    inst_sel = 2'b01;
    #1;
    n_cmp++;
    if (inst !== NOP) begin
      n_err++;
      $display("FAIL reset_inst_q: inst=%08h expected=%08h", inst, NOP);
    end
  endtask

  task automatic test_fetch();
    @(negedge clk);
    inst_sel = 2'b00;
    rdata    = 32'h0050_0093;
    #1;
    n_cmp++;
    if (inst !== 32'h0050_0093) begin
      n_err++;
      $display("FAIL fetch_0: inst=%08h expected=%08h", inst, 32'h0050_0093);
    end
    @(negedge clk);
    rdata = 32'h00A0_0113;
    #1;
    n_cmp++;
    if (inst !== 32'h00A0_0113) begin
      n_err++;
      $display("FAIL fetch_1: inst=%08h expected=%08h", inst, 32'h00A0_0113);
    end
  endtask

  task automatic test_hold();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      inst_sel = 2'b01;
      rdata    = 32'hDEAD_BEEF;
      #1;
      n_cmp++;
      if (inst !== 32'h00A0_0113) begin
        n_err++;
        $display("FAIL hold_cycle%0d: inst=%08h expected=%08h", c, inst, 32'h00A0_0113);
      end
    end
    @(negedge clk);
    inst_sel = 2'b00;
    #1;
    n_cmp++;
    if (inst !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL hold_release: inst=%08h expected=%08h", inst, 32'hDEAD_BEEF);
    end
  endtask

  task automatic test_flush_hold();
    @(negedge clk);
    inst_sel = 2'b10;
    rdata    = 32'h0020_81B3;
    #1;
    n_cmp++;
    if (inst !== NOP) begin
      n_err++;
      $display("FAIL flush: inst=%08h expected=%08h", inst, NOP);
    end
    @(negedge clk);
    inst_sel = 2'b01;
    #1;
    n_cmp++;
    if (inst !== NOP) begin
      n_err++;
      $display("FAIL hold_after_flush: inst=%08h expected=%08h", inst, NOP);
    end
    @(negedge clk);
    inst_sel = 2'b11;
    #1;
    n_cmp++;
    if (inst !== NOP) begin
      n_err++;
      $display("FAIL reserved_sel: inst=%08h expected=%08h", inst, NOP);
    end
  endtask

  task automatic test_reserved_then_hold();
    // Fetch a word, then reserved select, then hold: reserved must behave as
    // a flush, so the hold replays the bubble rather than the fetched word.
    @(negedge clk);
    inst_sel = 2'b00;
    rdata    = 32'h0031_0233;
    @(negedge clk);
    inst_sel = 2'b11;
    @(negedge clk);
    inst_sel = 2'b01;
    #1;
    n_cmp++;
    if (inst !== NOP) begin
      n_err++;
      $display("FAIL hold_after_reserved: inst=%08h expected=%08h", inst, NOP);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    inst_sel = 2'b00;
    rdata    = 32'h00A0_0113;
    @(negedge clk);
    inst_sel = 2'b01;
    rdata    = 32'h1234_5678;
    #1;
    n_cmp++;
    if (inst !== 32'h00A0_0113) begin
      n_err++;
      $display("FAIL async_pre_hold: inst=%08h expected=%08h", inst, 32'h00A0_0113);
    end
    // Pulse reset entirely between rising edges: only an asynchronous clear
    // can lose the held word.
    #1;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (inst !== NOP) begin
      n_err++;
      $display("FAIL async_during_reset: inst=%08h expected=%08h", inst, NOP);
    end
    #1;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (inst !== NOP) begin
      n_err++;
      $display("FAIL async_release_hold: inst=%08h expected=%08h", inst, NOP);
    end
    // Hold across a rising edge keeps the bubble.
    @(negedge clk);
    #1;
    n_cmp++;
    if (inst !== NOP) begin
      n_err++;
      $display("FAIL async_hold_next: inst=%08h expected=%08h", inst, NOP);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [4];
    words[0] = 32'h0000_0297;
    words[1] = 32'hFFFF_FFFF;
    words[2] = 32'h8000_0001;
    words[3] = 32'h0000_0000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      inst_sel = 2'b00;
      rdata    = words[i];
      #1;
      n_cmp++;
      if (inst !== words[i]) begin
        n_err++;
        $display("FAIL b2b_fetch%0d: inst=%08h expected=%08h", i, inst, words[i]);
      end
    end
    // Last delivered word is all-zero, which differs from the bubble.
    @(negedge clk);
    inst_sel = 2'b01;
    rdata    = 32'hCAFE_F00D;
    #1;
    n_cmp++;
    if (inst !== 32'h0000_0000) begin
      n_err++;
      $display("FAIL b2b_hold: inst=%08h expected=%08h", inst, 32'h0000_0000);
    end
  endtask

  initial begin
    rst      = 1'b0;
    inst_sel = 2'b00;
    rdata    = 32'h0;
    test_reset();
    test_fetch();
    test_hold();
    test_flush_hold();
    test_reserved_then_hold();
    test_async_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
